// File: rtl/waveform_pkg.sv
// Shared constants for the waveform display path.
// Pure declarations; no logic, no latency, no backpressure.
package waveform_pkg;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 10;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int SCREEN_W = 1024;
    localparam int SCREEN_H = 768;
    localparam int X_BEGIN  = 296;
    localparam int WIDTH    = 728;
    localparam int HCNT_W   = $clog2(SCREEN_W) + 1;
    localparam int VCNT_W   = $clog2(SCREEN_H);
endpackage

// File: rtl/waveform_sample_buffer_if.sv
// Sample-capture and pixel-lookup bundle between the ECG source, timing generator and renderer.
// Wires only; no latency, no backpressure (sample_valid is a strobe that cannot be refused).
interface waveform_sample_buffer_if
    import waveform_pkg::*;
#(
    parameter int DW = waveform_pkg::DATA_W
) ();
    logic [DW-1:0]     sample_in;
    logic              sample_valid;
    logic [HCNT_W-1:0] hcount;
    logic [VCNT_W-1:0] vcount;
    logic              frame_start;
    logic              freeze;
    logic [DW-1:0]     signal_out;
    logic              signal_ok;
    logic [HCNT_W-1:0] hcount_d;
    logic [VCNT_W-1:0] vcount_d;
    logic              overrun;

    modport master (
        output sample_in, sample_valid, hcount, vcount, frame_start, freeze,
        input  signal_out, signal_ok, hcount_d, vcount_d, overrun
    );

    modport slave (
        input  sample_in, sample_valid, hcount, vcount, frame_start, freeze,
        output signal_out, signal_ok, hcount_d, vcount_d, overrun
    );
endinterface

// File: rtl/waveform_bram.sv
// Simple dual-port block RAM, one write port and one synchronous read-first read port.
// Read latency 1 cycle, no backpressure; the array is never reset.
module waveform_bram
    import waveform_pkg::*;
#(
    parameter int AW = waveform_pkg::ADDR_W,
    parameter int DW = waveform_pkg::DATA_W
) (
    input  logic          clock,
    input  logic          wr_vld,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_dat_q;

    // Both updates are non-blocking, so a same-address read sees the old word.
    always_ff @(posedge clock) begin
        if (wr_vld)
            mem[wr_addr] <= wr_dat;
        rd_dat_q <= mem[rd_addr];
    end

    assign rd_dat = rd_dat_q;
endmodule

// File: rtl/waveform_sample_buffer.sv
// Circular ECG sample capture with a per-frame latched display window and freeze/overrun tracking.
// Pixel lookup latency 1 cycle; no backpressure, every decimated sample_valid strobe is stored.
module waveform_sample_buffer
    import waveform_pkg::*;
#(
    parameter int DEPTH    = waveform_pkg::DEPTH,
    parameter int ADDR_W   = waveform_pkg::ADDR_W,
    parameter int DATA_W   = waveform_pkg::DATA_W,
    parameter int X_BEGIN  = waveform_pkg::X_BEGIN,
    parameter int WIDTH    = waveform_pkg::WIDTH,
    parameter int DECIMATE = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    waveform_sample_buffer_if.slave  bus
);
    localparam int FW = ADDR_W + 1;
    localparam int CW = 16;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic [7:0]        dec_cnt_q, dec_cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [FW-1:0]     vis_q, vis_d;
    logic [FW-1:0]     frz_cnt_q, frz_cnt_d;
    logic              overrun_q, overrun_d;
    logic              ok_q, ok_d;
    logic [HCNT_W-1:0] hcnt_dly_q, hcnt_dly_d;
    logic [VCNT_W-1:0] vcnt_dly_q, vcnt_dly_d;

    logic              wr_en;
    logic [HCNT_W-1:0] col;
    logic              in_win;
    logic [FW-1:0]     thresh;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_dat;

    always_comb begin
        wr_en      = bus.sample_valid && (dec_cnt_q == 8'd0);
        dec_cnt_d  = dec_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q;
        base_d     = base_q;
        vis_d      = vis_q;
        frz_cnt_d  = '0;
        overrun_d  = 1'b0;

        if (bus.sample_valid)
            dec_cnt_d = (dec_cnt_q == 8'(DECIMATE - 1)) ? 8'd0 : dec_cnt_q + 8'd1;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (fill_q != FW'(DEPTH))
                fill_d = fill_q + 1'b1;
        end

        // Latch from the registered pointer so a same-cycle write lands in the next frame.
        if (bus.frame_start && !bus.freeze) begin
            base_d = wr_ptr_q - ADDR_W'(WIDTH);
            vis_d  = (fill_q > FW'(WIDTH)) ? FW'(WIDTH) : fill_q;
        end

        // Free slots outside the frozen window number DEPTH-WIDTH; one more write eats a visible column.
        if (bus.freeze) begin
            frz_cnt_d = frz_cnt_q;
            if (wr_en && frz_cnt_q != FW'(DEPTH))
                frz_cnt_d = frz_cnt_q + 1'b1;
            overrun_d = overrun_q || (frz_cnt_d > FW'(DEPTH - WIDTH));
        end

        col        = bus.hcount - HCNT_W'(X_BEGIN);
        in_win     = (bus.hcount >= HCNT_W'(X_BEGIN)) && (bus.hcount < HCNT_W'(X_BEGIN + WIDTH));
        thresh     = FW'(WIDTH) - vis_q;
        ok_d       = in_win && (CW'(col) >= CW'(thresh));
        rd_addr    = base_q + col[ADDR_W-1:0];
        hcnt_dly_d = bus.hcount;
        vcnt_dly_d = bus.vcount;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            dec_cnt_q  <= '0;
            base_q     <= '0;
            vis_q      <= '0;
            frz_cnt_q  <= '0;
            overrun_q  <= 1'b0;
            ok_q       <= 1'b0;
            hcnt_dly_q <= '0;
            vcnt_dly_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            dec_cnt_q  <= dec_cnt_d;
            base_q     <= base_d;
            vis_q      <= vis_d;
            frz_cnt_q  <= frz_cnt_d;
            overrun_q  <= overrun_d;
            ok_q       <= ok_d;
            hcnt_dly_q <= hcnt_dly_d;
            vcnt_dly_q <= vcnt_dly_d;
        end
    end

    waveform_bram #(
        .AW (ADDR_W),
        .DW (DATA_W)
    ) u_bram (
        .clock   (clock),
        .wr_vld  (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_dat  (bus.sample_in),
        .rd_addr (rd_addr),
        .rd_dat  (rd_dat)
    );

    // RAM output is unreset, so gating with the flag also gives the async-clear behaviour.
    assign bus.signal_out = ok_q ? rd_dat : '0;
    assign bus.signal_ok  = ok_q;
    assign bus.hcount_d   = hcnt_dly_q;
    assign bus.vcount_d   = vcnt_dly_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_waveform_sample_buffer.sv
// Directed bench for waveform_sample_buffer: one DECIMATE=1 instance and one DECIMATE=4 instance.
module tb_waveform_sample_buffer;
    logic clock;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    waveform_sample_buffer_if bus1 ();
    waveform_sample_buffer_if bus4 ();

    waveform_sample_buffer u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    waveform_sample_buffer #(.DECIMATE(4)) u_dut4 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_pix(input int h);
        bus1.hcount = 11'(h);
        bus4.hcount = 11'(h);
        bus1.vcount = 10'd100;
        bus4.vcount = 10'd100;
    endtask

    task automatic write1(input logic [7:0] v);
        bus1.sample_valid = 1'b1;
        bus1.sample_in    = v;
        tick();
        bus1.sample_valid = 1'b0;
    endtask

    task automatic frame1();
        bus1.frame_start = 1'b1;
        tick();
        bus1.frame_start = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic read_col(input string tag, input int h, input logic eok, input logic [7:0] ev);
        set_pix(h);
        tick();
        chk($sformatf("%s_ok@%0d", tag, h), {31'd0, bus1.signal_ok}, {31'd0, eok});
        chk($sformatf("%s_out@%0d", tag, h), {24'd0, bus1.signal_out}, {24'd0, ev});
    endtask

    // Full raster sweep; window columns lo..1022 follow first+step*(h-lo), column 1023 expects last.
    task automatic scan(input string tag, input bit sel, input int lo, input int first,
                        input int step, input int last);
        logic       ook;
        logic [7:0] oval;
        logic [10:0] ohd;
        logic [9:0] ovd;
        logic       eok;
        logic [7:0] ev;
        for (int h = 0; h < 1024; h++) begin
            set_pix(h);
            tick();
            if (h == lo - 1 || h == lo || h == lo + 1 || h == 1023 || h == 295 || (h % 128) == 0) begin
                ook  = sel ? bus4.signal_ok  : bus1.signal_ok;
                oval = sel ? bus4.signal_out : bus1.signal_out;
                ohd  = sel ? bus4.hcount_d   : bus1.hcount_d;
                ovd  = sel ? bus4.vcount_d   : bus1.vcount_d;
                eok  = (h >= lo);
                if (!eok)
                    ev = 8'h00;
                else if (h == 1023)
                    ev = 8'(last);
                else
                    ev = 8'(first + step * (h - lo));
                chk($sformatf("%s_ok@%0d", tag, h), {31'd0, ook}, {31'd0, eok});
                chk($sformatf("%s_out@%0d", tag, h), {24'd0, oval}, {24'd0, ev});
                chk($sformatf("%s_hd@%0d", tag, h), {21'd0, ohd}, 32'(h));
                chk($sformatf("%s_vd@%0d", tag, h), {22'd0, ovd}, 32'd100);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        bus1.sample_in = '0; bus1.sample_valid = 1'b0; bus1.frame_start = 1'b0; bus1.freeze = 1'b0;
        bus4.sample_in = '0; bus4.sample_valid = 1'b0; bus4.frame_start = 1'b0; bus4.freeze = 1'b0;
        set_pix(400);

        // Reset state, before and across a clock edge.
        #3;
        chk("rst_out", {24'd0, bus1.signal_out}, 32'd0);
        chk("rst_ok", {31'd0, bus1.signal_ok}, 32'd0);
        chk("rst_hd", {21'd0, bus1.hcount_d}, 32'd0);
        chk("rst_vd", {22'd0, bus1.vcount_d}, 32'd0);
        chk("rst_ovr", {31'd0, bus1.overrun}, 32'd0);
        tick();
        chk("rst_hd_clk", {21'd0, bus1.hcount_d}, 32'd0);
        reset_n = 1'b1;
        tick();

        // DECIMATE=4: 40 strobes 0..39 keep 0,4,..,36 in the newest 10 columns.
        for (int n = 0; n < 40; n++) begin
            bus4.sample_valid = 1'b1;
            bus4.sample_in    = 8'(n);
            tick();
        end
        bus4.sample_valid = 1'b0;
        bus4.frame_start  = 1'b1;
        tick();
        bus4.frame_start  = 1'b0;
        scan("dec4", 1'b1, 1014, 0, 4, 36);

        // Exactly one full window of samples.
        for (int n = 0; n < 728; n++) write1(8'(n));
        frame1();
        scan("full", 1'b0, 296, 0, 1, 8'hD7);

        // Partial fill: only the rightmost 100 columns are valid.
        pulse_reset();
        for (int n = 0; n < 100; n++) write1(8'(n));
        frame1();
        scan("part", 1'b0, 924, 0, 1, 99);

        // Frame latch coinciding with a write uses the pre-write pointer.
        for (int n = 100; n < 728; n++) write1(8'(n));
        bus1.frame_start  = 1'b1;
        bus1.sample_valid = 1'b1;
        bus1.sample_in    = 8'hAA;
        tick();
        bus1.frame_start  = 1'b0;
        bus1.sample_valid = 1'b0;
        scan("samecyc", 1'b0, 296, 0, 1, 8'hD7);
        frame1();
        scan("nextfrm", 1'b0, 296, 1, 1, 8'hAA);

        // Freeze and overrun.
        pulse_reset();
        for (int n = 0; n < 1024; n++) write1(8'(n));
        frame1();
        scan("prefrz", 1'b0, 296, 8'h28, 1, 8'hFF);
        bus1.freeze = 1'b1;
        for (int n = 0; n < 296; n++) write1(8'hEE);
        chk("ovr_296", {31'd0, bus1.overrun}, 32'd0);
        frame1();
        scan("frozen", 1'b0, 296, 8'h28, 1, 8'hFF);
        chk("ovr_frozen", {31'd0, bus1.overrun}, 32'd0);
        // 297th write hits the address being read at column 296: old data comes back.
        set_pix(296);
        bus1.sample_valid = 1'b1;
        bus1.sample_in    = 8'h5A;
        tick();
        bus1.sample_valid = 1'b0;
        chk("coll_out", {24'd0, bus1.signal_out}, 32'h28);
        chk("coll_ok", {31'd0, bus1.signal_ok}, 32'd1);
        chk("ovr_297", {31'd0, bus1.overrun}, 32'd1);
        read_col("coll_new", 296, 1'b1, 8'h5A);
        bus1.freeze = 1'b0;
        tick();
        chk("ovr_clear", {31'd0, bus1.overrun}, 32'd0);
        frame1();
        read_col("unfrz", 296, 1'b1, 8'h51);
        read_col("unfrz", 726, 1'b1, 8'hFF);
        read_col("unfrz", 727, 1'b1, 8'hEE);
        read_col("unfrz", 1022, 1'b1, 8'hEE);
        read_col("unfrz", 1023, 1'b1, 8'h5A);

        // Asynchronous reset in the middle of a scan line.
        read_col("prerst", 500, 1'b1, 8'h1D);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out", {24'd0, bus1.signal_out}, 32'd0);
        chk("arst_ok", {31'd0, bus1.signal_ok}, 32'd0);
        chk("arst_hd", {21'd0, bus1.hcount_d}, 32'd0);
        chk("arst_vd", {22'd0, bus1.vcount_d}, 32'd0);
        chk("arst_ovr", {31'd0, bus1.overrun}, 32'd0);
        #3;
        reset_n = 1'b1;
        read_col("postrst", 500, 1'b0, 8'h00);
        chk("postrst_hd", {21'd0, bus1.hcount_d}, 32'd500);
        write1(8'h33);
        read_col("nolatch", 1023, 1'b0, 8'h00);
        frame1();
        read_col("onewr", 1023, 1'b1, 8'h33);
        read_col("onewr", 1022, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/waveform_sample_buffer.md
Name: waveform_sample_buffer

Overview:
- Writer side of the waveform display path.
- Captures the 8-bit ECG sample stream into a circular buffer. On each pixel, returns the sample for the current screen column, with the matching delayed hcount/vcount, to the waveform renderer.
- The display window base is latched once per frame, so the trace never tears mid-frame. A freeze input holds the trace on screen while capture continues.

Parameters:
- DEPTH, 1024, buffer entries; power of two.
- ADDR_W, 10, log2(DEPTH).
- DATA_W, 8, sample width.
- X_BEGIN, 296, first screen column of the trace.
- WIDTH, 728, trace width in columns; must be <= DEPTH.
- DECIMATE, 1, store one of every DECIMATE valid samples; range 1..255.

Ports:
- clock  in  1  pixel clock (65 MHz domain)
- reset_n  in  1  asynchronous active-low reset
- sample_in  in  DATA_W  incoming sample
- sample_valid  in  1  one-cycle strobe; sample_in is sampled on this cycle
- hcount  in  11  current pixel column
- vcount  in  10  current pixel row
- frame_start  in  1  one-cycle pulse at start of vertical blank
- freeze  in  1  level; 1 = hold displayed window
- signal_out  out  DATA_W  sample for column hcount_d
- signal_ok  out  1  signal_out holds a written sample inside the trace window
- hcount_d  out  11  hcount delayed 1 cycle
- vcount_d  out  10  vcount delayed 1 cycle
- overrun  out  1  sticky: frozen window was overwritten

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr, fill, dec_cnt, base all clear to 0.
  - signal_out=0, signal_ok=0, hcount_d=0, vcount_d=0, overrun=0.
  - RAM contents are not cleared.
- Write side:
  - On sample_valid, dec_cnt increments, wrapping at DECIMATE-1.
  - A write happens when sample_valid=1 and dec_cnt==0: RAM[wr_ptr] <= sample_in, then wr_ptr <= wr_ptr+1 mod DEPTH.
  - fill increments on each write and saturates at DEPTH.
- Base latch:
  - On frame_start with freeze=0: base <= wr_ptr - WIDTH (mod DEPTH), and vis <= min(fill, WIDTH).
  - Both values use the pre-write wr_ptr/fill, even if a write occurs on the same cycle.
  - On frame_start with freeze=1: base and vis hold.
- Read side, 1-cycle latency:
  - col = hcount - X_BEGIN.
  - in_win = (hcount >= X_BEGIN) && (hcount < X_BEGIN+WIDTH).
  - Read address = base + col[ADDR_W-1:0] mod DEPTH.
  - Next cycle: signal_out = RAM data; hcount_d/vcount_d = the previous hcount/vcount.
  - signal_ok = in_win && (col >= WIDTH - vis), registered alongside the data.
  - Outside the window, or when signal_ok=0, signal_out = 0.
- Ordering: leftmost column is the oldest sample, rightmost is the newest written before the latch.
- Read/write collision on the same address in the same cycle is read-first: the old data is returned.
- Overrun:
  - While frozen, count writes since freeze rose (saturate at DEPTH).
  - When the count exceeds DEPTH - WIDTH, set overrun=1; frozen columns are now being overwritten.
  - overrun clears on the first cycle freeze=0.
- freeze toggling mid-frame has no visible effect until the next frame_start.
- Reset mid-frame: outputs clear immediately. signal_ok stays 0 until the first frame_start after at least one write.

Decomposition:
- Shared package waveform_pkg holds the constants:
  - DATA_W, ADDR_W
  - SCREEN_W=1024, SCREEN_H=768
  - X_BEGIN, WIDTH
- Sub-module waveform_bram: simple dual-port RAM, DEPTH x DATA_W.
  - One write port, one synchronous read port, read-first.
  - Infers block RAM; no reset on the array.

Test Plan:
- Reset, write 728 samples of value n mod 256, pulse frame_start, scan hcount 0..1023 -> signal_ok=1 only for hcount_d 296..1023; signal_out at hcount_d=296 is 0x00, at hcount_d=1023 is 0xD7 (727 mod 256).
- Write only 100 samples, then frame_start -> signal_ok=0 for hcount_d 296..923; columns 924..1023 show values 0..99.
- DECIMATE=4, 40 sample_valid strobes with values 0..39 -> fill=10; stored values are 0,4,...,36.
- Fill the buffer, assert freeze, write 296 more samples (DEPTH-WIDTH), then frame_start -> display unchanged, overrun=0. Write 1 more -> overrun=1. Deassert freeze -> overrun=0, and the next frame shows the newest 728 samples.
- Assert frame_start on the same cycle as a write -> base uses the pre-write wr_ptr; the new sample does not appear until the next frame.
- Assert reset_n=0 mid-scan at hcount=500 -> all outputs are 0 within the same cycle (async); after release, signal_ok=0 until a write followed by frame_start.
